// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: video mode constant sets and coordinate-width helper for vga_timing_gen.
package vga_timing_pkg;
  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } vga_mode_t;
  localparam vga_mode_t MODE_480P = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam vga_mode_t MODE_720P = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
  function automatic int vga_cw(input int h_total, input int v_total);
    return $clog2(h_total > v_total ? h_total : v_total);
  endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel strobe in, raster timing out; o_frame exists only with VGA_FRAME_COUNTER_EN.
interface vga_timing_if #(parameter int CW = 11);
  logic          i_pix_stb;
  logic          o_hs;
  logic          o_vs;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_de;
  logic          o_line_start;
  logic          o_frame_start;
  logic          o_animate;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0]   o_frame;
`endif
  modport master (
    input  i_pix_stb,
    output o_hs, o_vs, o_x, o_y, o_de, o_line_start, o_frame_start, o_animate
`ifdef VGA_FRAME_COUNTER_EN
    , o_frame
`endif
  );
  modport slave (
    output i_pix_stb,
    input  o_hs, o_vs, o_x, o_y, o_de, o_line_start, o_frame_start, o_animate
`ifdef VGA_FRAME_COUNTER_EN
    , o_frame
`endif
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping raster axis counter; exposes the next value so decode can stay skew-free.
module vga_axis_counter #(
  parameter int CW = 11
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [CW-1:0] i_limit,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_next,
  output logic          o_wrap
);
  logic [CW-1:0] r_count;
  assign o_count = r_count;
  assign o_wrap  = r_count == i_limit;
  assign o_next  = !i_en ? r_count : o_wrap ? '0 : r_count + 1'b1;
  always_ff @(posedge i_clk) r_count <= i_rst ? '0 : o_next;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator (sync, coordinates, DE, event pulses).
// Optional 16-bit frame counter output enabled by VGA_FRAME_COUNTER_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_720P.h_active,
  parameter int H_FP     = MODE_720P.h_fp,
  parameter int H_SYNC   = MODE_720P.h_sync,
  parameter int H_BP     = MODE_720P.h_bp,
  parameter int V_ACTIVE = MODE_720P.v_active,
  parameter int V_FP     = MODE_720P.v_fp,
  parameter int V_SYNC   = MODE_720P.v_sync,
  parameter int V_BP     = MODE_720P.v_bp,
  parameter bit HS_POL   = MODE_720P.hs_pol,
  parameter bit VS_POL   = MODE_720P.vs_pol,
  parameter int CW       = vga_cw(H_ACTIVE + H_FP + H_SYNC + H_BP, V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input logic          i_clk,
  input logic          i_rst,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // inclusive bounds keep every constant representable in CW bits
  localparam logic [CW-1:0] H_LIM      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LIM      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_BLANK    = CW'(V_ACTIVE);
  logic [CW-1:0] w_hn, w_vn;
  logic          w_h_wrap, w_v_wrap, w_v_en;
  logic          r_hs, r_vs, r_de, r_line_start, r_frame_start, r_animate;
  assign w_v_en = bus.i_pix_stb & w_h_wrap;
  vga_axis_counter #(.CW(CW)) u_h (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(bus.i_pix_stb), .i_limit(H_LIM),
    .o_count(bus.o_x), .o_next(w_hn), .o_wrap(w_h_wrap)
  );
  vga_axis_counter #(.CW(CW)) u_v (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_v_en), .i_limit(V_LIM),
    .o_count(bus.o_y), .o_next(w_vn), .o_wrap(w_v_wrap)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hs          <= !HS_POL;
      r_vs          <= !VS_POL;
      r_de          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_animate     <= 1'b0;
    end else begin
      r_hs          <= (w_hn >= HS_FIRST && w_hn <= HS_LAST) ? HS_POL : !HS_POL;
      r_vs          <= (w_vn >= VS_FIRST && w_vn <= VS_LAST) ? VS_POL : !VS_POL;
      r_de          <= w_hn <= H_ACT_LAST && w_vn <= V_ACT_LAST;
      r_line_start  <= w_v_en;
      r_frame_start <= w_v_en & w_v_wrap;
      r_animate     <= w_v_en && w_vn == V_BLANK;
    end
  end
  assign bus.o_hs          = r_hs;
  assign bus.o_vs          = r_vs;
  assign bus.o_de          = r_de;
  assign bus.o_line_start  = r_line_start;
  assign bus.o_frame_start = r_frame_start;
  assign bus.o_animate     = r_animate;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] r_frame;
  always_ff @(posedge i_clk) r_frame <= i_rst ? '0 : r_frame + 16'(w_v_en & w_v_wrap);
  assign bus.o_frame = r_frame;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-mode raster checks against a reference model with a scoreboard queue.
module tb_vga_timing_gen;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic       an;
  } obs_t;
  typedef struct {
    bit         rst;
    bit         stb;
    logic [3:0] x;
    logic [3:0] y;
    logic       de;
    logic       ls;
    logic       fs;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  obs_t q[$];
  obs_t last;
  int   passes = 0, total = 0;
  int   mx = 0, my = 0;
  logic e_ls = 0, e_fs = 0, e_an = 0;
  int   cyc = 0;
  bit   measure = 0;
  int   n_de = 0, n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0, n_an = 0, last_fs = -1;
  int   max_x = 0, max_y = 0;
  vga_timing_if #(.CW(4)) if0 ();
  vga_timing_if #(.CW(4)) if1 ();
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
  ) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4)
  ) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic tick(input bit r, input bit s);
    obs_t e, a, a1;
    bit hw;
    rst = r;
    if0.i_pix_stb = s;
    if1.i_pix_stb = s;
    if (r) begin
      mx = 0; my = 0; e_ls = 0; e_fs = 0; e_an = 0;
    end else if (s) begin
      hw = mx == 13;
      mx = hw ? 0 : mx + 1;
      if (hw) my = (my == 6) ? 0 : my + 1;
      e_ls = hw; e_fs = hw && my == 0; e_an = hw && my == 4;
    end else begin
      e_ls = 0; e_fs = 0; e_an = 0;
    end
    e = {4'(mx), 4'(my), mx >= 10 && mx <= 11, my == 5, mx < 8 && my < 4, e_ls, e_fs, e_an};
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = q.pop_front();
    a  = {if0.o_x, if0.o_y, if0.o_hs, if0.o_vs, if0.o_de, if0.o_line_start, if0.o_frame_start, if0.o_animate};
    a1 = {if1.o_x, if1.o_y, if1.o_hs, if1.o_vs, if1.o_de, if1.o_line_start, if1.o_frame_start, if1.o_animate};
    chk("raster", 16'(a), 16'(e));
    chk("raster_pol0", 16'(a1), 16'({e.x, e.y, ~e.hs, ~e.vs, e.de, e.ls, e.fs, e.an}));
    last = a;
    if (int'(a.x) > max_x) max_x = int'(a.x);
    if (int'(a.y) > max_y) max_y = int'(a.y);
    if (measure) begin
      n_de += int'(a.de); n_hs += int'(a.hs); n_vs += int'(a.vs);
      n_ls += int'(a.ls); n_an += int'(a.an);
      if (a.fs) begin
        n_fs++;
        if (last_fs >= 0) chk("fs_period", 16'(cyc - last_fs), 16'd98);
        last_fs = cyc;
      end
    end
  endtask
  initial begin
    vec_t tbl[4];
    tbl[0] = '{1, 1, 4'd0, 4'd0, 1, 0, 0};
    tbl[1] = '{0, 1, 4'd1, 4'd0, 1, 0, 0};
    tbl[2] = '{0, 0, 4'd1, 4'd0, 1, 0, 0};
    tbl[3] = '{0, 1, 4'd2, 4'd0, 1, 0, 0};
    tick(1, 0);
    tick(1, 1);
    chk("rst_x", 16'(if0.o_x), 16'd0);
    chk("rst_y", 16'(if0.o_y), 16'd0);
    chk("rst_de", 16'(if0.o_de), 16'd1);
    chk("rst_hs_vs_pol1", 16'({if0.o_hs, if0.o_vs}), 16'b00);
    chk("rst_hs_vs_pol0", 16'({if1.o_hs, if1.o_vs}), 16'b11);
    chk("rst_pulses", 16'({if0.o_line_start, if0.o_frame_start, if0.o_animate}), 16'd0);
    measure = 1;
    for (int i = 0; i < 294; i++) tick(0, 1);
    measure = 0;
    chk("de_count", 16'(n_de), 16'd96);
    chk("hs_count", 16'(n_hs), 16'd42);
    chk("vs_count", 16'(n_vs), 16'd42);
    chk("ls_count", 16'(n_ls), 16'd21);
    chk("fs_count", 16'(n_fs), 16'd3);
    chk("animate_count", 16'(n_an), 16'd3);
`ifdef VGA_FRAME_COUNTER_EN
    chk("frame_cnt", 16'(if0.o_frame), 16'd3);
`endif
    tick(1, 0);
    for (int i = 0; i < 47; i++) tick(0, 1);
    chk("pre_rst_xy", 16'({last.x, last.y}), 16'({4'd5, 4'd3}));
    for (int i = 0; i < 4; i++) begin
      tick(tbl[i].rst, tbl[i].stb);
      chk($sformatf("vec%0d", i), 16'({last.x, last.y, last.de, last.ls, last.fs}),
          16'({tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].ls, tbl[i].fs}));
    end
    for (int i = 0; i < 2000; i++) tick(0, $urandom_range(0, 99) < 30);
    chk("max_x", 16'(max_x), 16'd13);
    chk("max_y", 16'(max_y), 16'd6);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
